// File: rtl/eq_gain_sequencer_if.sv
// Command and gain-bus bundle for the EQ gain sequencer.
// The "master" view belongs to the sequencer. It takes the user commands and drives
// the shared gain bus, the set strobes, busy and the exported table.
// The "slave" view is the opposite side: command source, biquads and display.
interface eq_gain_sequencer_if #(
    parameter int N_BANDS = 8
) ();
    localparam int BW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;

    // debounced single-cycle user commands
    logic                    i_band_next;
    logic                    i_band_prev;
    logic                    i_gain_up;
    logic                    i_gain_down;
    logic                    i_flat;

    // biquad-side gain/set handshake and status
    logic [BW-1:0]           o_band;
    logic [15:0]             o_gain;
    logic [N_BANDS-1:0]      o_set;
    logic                    o_busy;
    logic [16*N_BANDS-1:0]   o_gain_table;

    modport master (
        input  i_band_next, i_band_prev, i_gain_up, i_gain_down, i_flat,
        output o_band, o_gain, o_set, o_busy, o_gain_table
    );

    modport slave (
        output i_band_next, i_band_prev, i_gain_up, i_gain_down, i_flat,
        input  o_band, o_gain, o_set, o_busy, o_gain_table
    );
endinterface

// File: rtl/eq_gain_sequencer.sv
// EQ gain sequencer. It turns band-select, gain-step and flatten commands into
// per-biquad gain/set strobes and serialises every update.
// The biquads have no done flag, so each set strobe is followed by a fixed settle window.
// The design keeps the gain table and exports it for the display.
module eq_gain_sequencer #(
    parameter int N_BANDS       = 8,
    parameter int GAIN_MAX      = 12,
    parameter int GAIN_MIN      = -12,
    parameter int GAIN_STEP     = 1,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    eq_gain_sequencer_if.master   bus
);
    localparam int BW = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_FLAT   = 2'd3;

    localparam logic [BW-1:0]        L_LAST_BAND = BW'(N_BANDS - 1);
    localparam logic [CW-1:0]        L_LAST_CNT  = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_BANDS-1:0]   L_ONE       = {{(N_BANDS-1){1'b0}}, 1'b1};
    localparam logic signed [17:0]   L_STEP      = 18'(GAIN_STEP);
    localparam logic signed [17:0]   L_MAX       = 18'(GAIN_MAX);
    localparam logic signed [17:0]   L_MIN       = 18'(GAIN_MIN);
    localparam logic signed [15:0]   L_MAX16     = 16'(GAIN_MAX);
    localparam logic signed [15:0]   L_MIN16     = 16'(GAIN_MIN);

    logic [1:0]              r_state;
    logic                    r_bcast;     // current ISSUE/SETTLE belongs to a flatten broadcast
    logic [BW-1:0]           r_band;
    logic [BW-1:0]           r_flat_idx;
    logic [CW-1:0]           r_cnt;
    logic signed [15:0]      r_gain;
    logic [N_BANDS-1:0]      r_set;
    logic signed [15:0]      r_table [N_BANDS];

    logic                    w_gain_inc;
    logic                    w_gain_dec;
    logic                    w_gain_both;
    logic signed [15:0]      w_cur;
    logic signed [17:0]      w_cand;
    logic signed [15:0]      w_new;
    logic                    w_changed;

    // Decode the gain command and compute the saturated candidate for the selected band.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_gain_inc  = bus.i_gain_up & ~bus.i_gain_down;
        w_gain_dec  = bus.i_gain_down & ~bus.i_gain_up;
        w_gain_both = bus.i_gain_up & bus.i_gain_down;
        w_cur       = r_table[r_band];
        w_cand      = {{2{w_cur[15]}}, w_cur};
        if (w_gain_inc) begin
            w_cand = w_cand + L_STEP;
        end else if (w_gain_dec) begin
            w_cand = w_cand - L_STEP;
        end
        if (w_cand > L_MAX) begin
            w_new = L_MAX16;
        end else if (w_cand < L_MIN) begin
            w_new = L_MIN16;
        end else begin
            w_new = w_cand[15:0];
        end
        w_changed = (w_new != w_cur);
    end

    // Sequencer FSM, gain table and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the table is only N_BANDS words and must read as zero after reset, so it is reset like any other register.
            for (int k = 0; k < N_BANDS; k++) begin
                r_table[k] <= '0;
            end
            r_state    <= S_FLAT;
            r_bcast    <= 1'b1;
            r_band     <= '0;
            r_flat_idx <= '0;
            r_cnt      <= '0;
            r_gain     <= '0;
            r_set      <= '0;
        end else begin
            // NOTE: all state updates use non-blocking assignments, so every branch reads the pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (bus.i_flat) begin
                        for (int k = 0; k < N_BANDS; k++) begin
                            r_table[k] <= '0;
                        end
                        r_flat_idx <= '0;
                        r_bcast    <= 1'b1;
                        r_state    <= S_FLAT;
                    end else if (w_gain_inc || w_gain_dec) begin
                        // A gain command outranks band commands. A saturated no-op produces no strobe.
                        if (w_changed) begin
                            r_table[r_band] <= w_new;
                            r_gain          <= w_new;
                            r_set           <= L_ONE << r_band;
                            r_bcast         <= 1'b0;
                            r_state         <= S_ISSUE;
                        end
                    end else if (!w_gain_both) begin
                        if (bus.i_band_next && !bus.i_band_prev) begin
                            r_band <= (r_band == L_LAST_BAND) ? '0 : r_band + 1'b1;
                        end else if (bus.i_band_prev && !bus.i_band_next) begin
                            r_band <= (r_band == '0) ? L_LAST_BAND : r_band - 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_set   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == L_LAST_CNT) begin
                        if (!r_bcast || r_flat_idx == L_LAST_BAND) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_flat_idx <= r_flat_idx + 1'b1;
                            r_state    <= S_FLAT;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FLAT: begin
                    r_gain  <= '0;
                    r_set   <= L_ONE << r_flat_idx;
                    r_state <= S_ISSUE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Export the table packed for the display, band k at [16k+15:16k].
    for (genvar g = 0; g < N_BANDS; g++) begin : g_table
        assign bus.o_gain_table[16*g +: 16] = r_table[g];
    end

    assign bus.o_band = r_band;
    assign bus.o_gain = r_gain;
    assign bus.o_set  = r_set;
    assign bus.o_busy = (r_state != S_IDLE);

endmodule
